// File: rtl/alu_rpn_controller_if.sv
// -----------------------------------------------------------------------------
// alu_rpn_controller_if
// Bus between the RPN front-end controller and the combinational ALU.
//   A, B    : operands, driven by the controller (M bits each)
//   OpCode  : 2-bit operation select, driven by the controller
//   Result  : ALU result, combinational from A/B/OpCode (M bits)
//   Flags   : ALU status flags (NFLAG bits)
// modport master : controller side (drives operands/opcode, reads result/flags)
// modport slave  : ALU side (reads operands/opcode, drives result/flags)
// -----------------------------------------------------------------------------
interface alu_rpn_controller_if #(
    parameter int M     = 7,
    parameter int NFLAG = 5
);
    logic [M-1:0]     A;
    logic [M-1:0]     B;
    logic [1:0]       OpCode;
    logic [M-1:0]     Result;
    logic [NFLAG-1:0] Flags;

    modport master (
        output A,
        output B,
        output OpCode,
        input  Result,
        input  Flags
    );

    modport slave (
        input  A,
        input  B,
        input  OpCode,
        output Result,
        output Flags
    );
endinterface

// File: rtl/alu_rpn_controller.sv
// -----------------------------------------------------------------------------
// alu_rpn_controller
// Sequential front-end for an M-bit combinational ALU. Operands and opcode are
// entered from switches in reverse-polish order using debounced enter/undo
// buttons. The ALU result and flags are captured one cycle after the opcode is
// loaded, and a display value is selected according to the entry stage.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   data_in   in   operand switches (M bits)
//   op_in     in   opcode switches (2 bits)
//   enter     in   enter button level, a rising edge is one command
//   undo      in   undo button level, a rising edge is one command
//   alu       if   ALU bus (master): A, B, OpCode out; Result, Flags in
//   result_q  out  captured ALU result
//   flags_q   out  captured ALU flags
//   disp_val  out  value for the display path
//   state     out  current FSM state encoding
//   valid     out  high while result_q/flags_q hold a fresh result
// -----------------------------------------------------------------------------
module alu_rpn_controller #(
    parameter int M     = 7,
    parameter int NFLAG = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [M-1:0]         data_in,
    input  logic [1:0]           op_in,
    input  logic                 enter,
    input  logic                 undo,
    alu_rpn_controller_if.master alu,
    output logic [M-1:0]         result_q,
    output logic [NFLAG-1:0]     flags_q,
    output logic [M-1:0]         disp_val,
    output logic [2:0]           state,
    output logic                 valid
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        CALC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [M-1:0]     a_q, a_d;
    logic [M-1:0]     b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [M-1:0]     res_q, res_d;
    logic [NFLAG-1:0] flg_q, flg_d;
    logic             valid_q, valid_d;
    logic             enter_prev_q;
    logic             undo_prev_q;

    logic             undo_e_s;
    logic             enter_e_s;
    logic [M-1:0]     disp_s;

    // Button edge detection; a simultaneous undo suppresses the enter command.
    always_comb begin
        undo_e_s  = undo & ~undo_prev_q;
        enter_e_s = enter & ~enter_prev_q & ~undo_e_s;
    end

    // State and datapath registers with synchronous reset. The prev registers
    // reset to 1 so a button already held through reset does not fire.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_A;
            a_q          <= {M{1'b0}};
            b_q          <= {M{1'b0}};
            op_q         <= 2'b00;
            res_q        <= {M{1'b0}};
            flg_q        <= {NFLAG{1'b0}};
            valid_q      <= 1'b0;
            enter_prev_q <= 1'b1;
            undo_prev_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            res_q        <= res_d;
            flg_q        <= flg_d;
            valid_q      <= valid_d;
            enter_prev_q <= enter;
            undo_prev_q  <= undo;
        end
    end

    // Next-state and register-load decisions for the RPN entry sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        flg_d   = flg_q;
        valid_d = valid_q;

        case (state_q)
            WAIT_A: begin
                // undo has nothing to step back to here
                if (enter_e_s) begin
                    a_d     = data_in;
                    state_d = WAIT_B;
                end else begin
                    state_d = WAIT_A;
                end
            end

            WAIT_B: begin
                if (undo_e_s) begin
                    state_d = WAIT_A;
                end else if (enter_e_s) begin
                    b_d     = data_in;
                    state_d = WAIT_OP;
                end else begin
                    state_d = WAIT_B;
                end
            end

            WAIT_OP: begin
                if (undo_e_s) begin
                    state_d = WAIT_B;
                end else if (enter_e_s) begin
                    op_d    = op_in;
                    state_d = CALC;
                end else begin
                    state_d = WAIT_OP;
                end
            end

            CALC: begin
                // A/B/OpCode have been stable for this whole cycle, so the
                // combinational ALU output is settled; buttons are ignored.
                res_d   = alu.Result;
                flg_d   = alu.Flags;
                valid_d = 1'b1;
                state_d = SHOW;
            end

            SHOW: begin
                if (undo_e_s) begin
                    valid_d = 1'b0;
                    state_d = WAIT_A;
                end else if (enter_e_s) begin
                    // chain the previous result in as the next first operand
                    a_d     = res_q;
                    valid_d = 1'b0;
                    state_d = WAIT_B;
                end else begin
                    state_d = SHOW;
                end
            end

            default: begin
                state_d = WAIT_A;
                valid_d = 1'b0;
            end
        endcase
    end

    // Display source follows the entry stage: switches, opcode, or result.
    always_comb begin
        disp_s = {M{1'b0}};
        case (state_q)
            WAIT_A:  disp_s = data_in;
            WAIT_B:  disp_s = data_in;
            WAIT_OP: disp_s = {{(M-2){1'b0}}, op_in};
            CALC:    disp_s = res_q;
            SHOW:    disp_s = res_q;
            default: disp_s = {M{1'b0}};
        endcase
    end

    assign alu.A      = a_q;
    assign alu.B      = b_q;
    assign alu.OpCode = op_q;
    assign result_q   = res_q;
    assign flags_q    = flg_q;
    assign valid      = valid_q;
    assign state      = state_q;
    assign disp_val   = disp_s;

endmodule
